// File: rtl/seg7_pkg.sv
// Shared types and the active-low hex segment table for the 7-segment capture block.
package seg7_pkg;

    localparam int unsigned SEG_W = 8;
    localparam int unsigned NIB_W = 4;

    typedef logic [SEG_W-1:0] seg_word_t;

    typedef struct packed {
        logic             valid;
        logic [NIB_W-1:0] nib;
    } hex_dec_t;

    // Active-low a..g patterns, entry i displays hex digit i.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/module_seg7_to_hex.sv
// Combinational inverse of the hex segment table: 7 active-low segments to {valid, nibble}.
module module_seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0]       seg,
    output logic             valid_c,
    output logic [NIB_W-1:0] nib_c
);

    hex_dec_t dec;

    always_comb begin
        dec = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_PAT[i]) begin
                dec.valid = 1'b1;
                dec.nib   = NIB_W'(i);
            end
        end
    end

    assign valid_c = dec.valid;
    assign nib_c   = dec.nib;

endmodule

// File: rtl/module_seg7_capture.sv
// Recovers the 16-bit hex value and decimal points from a multiplexed active-low 7-segment bus.
// Optional saturating error counter enabled by defining SEG7_CAP_ERRCNT_EN.
module module_seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned N_DIG      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             seg,
    input  logic [N_DIG-1:0]       an,
    output logic [NIB_W*N_DIG-1:0] value,
    output logic [N_DIG-1:0]       dp_o,
    output logic                   frame_valid,
    output logic                   err,
    output logic [7:0]             err_cnt
);

    localparam int unsigned CNT_W = 8;

    seg_word_t                     seg_m, s_seg, prev_seg;
    logic [N_DIG-1:0]              an_m, s_an, prev_an;
    logic [CNT_W-1:0]              cnt;
    logic                          held;
    logic [N_DIG-1:0]              seen, stage_dp;
    logic [N_DIG-1:0][NIB_W-1:0]   stage_nib;

    logic                          legal_c, same_c, accept_c, done_c;
    logic                          dec_valid_c;
    logic [NIB_W-1:0]              dec_nib_c;
    logic [N_DIG-1:0]              seen_nx_c, dp_nx_c;
    logic [N_DIG-1:0][NIB_W-1:0]   nib_nx_c;

    // Two-flop synchronizers plus the previous-sample copy used for stability checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m    <= 8'hFF;
            s_seg    <= 8'hFF;
            prev_seg <= 8'hFF;
            an_m     <= '1;
            s_an     <= '1;
            prev_an  <= '1;
        end else begin
            seg_m    <= seg;
            s_seg    <= seg_m;
            prev_seg <= s_seg;
            an_m     <= an;
            s_an     <= an_m;
            prev_an  <= s_an;
        end
    end

    module_seg7_to_hex u_to_hex (
        .seg     (s_seg[6:0]),
        .valid_c (dec_valid_c),
        .nib_c   (dec_nib_c)
    );

    assign legal_c  = $onehot(~s_an);
    assign same_c   = (s_an == prev_an) && (s_seg == prev_seg);
    // Accept on the edge where the counter would reach STABLE_CNT.
    assign accept_c = legal_c && same_c && !held && (cnt == CNT_W'(STABLE_CNT - 1));

    always_comb begin
        seen_nx_c = seen;
        nib_nx_c  = stage_nib;
        dp_nx_c   = stage_dp;
        if (accept_c && dec_valid_c) begin
            for (int i = 0; i < int'(N_DIG); i++) begin
                if (!s_an[i]) begin
                    seen_nx_c[i] = 1'b1;
                    nib_nx_c[i]  = dec_nib_c;
                    dp_nx_c[i]   = ~s_seg[7];
                end
            end
        end
    end

    assign done_c = &seen_nx_c;

    // Dwell counter and once-per-dwell accepted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            held <= 1'b0;
        end else if (!legal_c) begin
            cnt  <= '0;
            held <= 1'b0;
        end else if (same_c) begin
            if (cnt < CNT_W'(STABLE_CNT)) cnt <= cnt + CNT_W'(1);
            held <= held | accept_c;
        end else begin
            cnt  <= CNT_W'(1);
            held <= 1'b0;
        end
    end

    // Staging, frame completion and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen        <= '0;
            stage_nib   <= '0;
            stage_dp    <= '0;
            value       <= '0;
            dp_o        <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            stage_nib   <= nib_nx_c;
            stage_dp    <= dp_nx_c;
            seen        <= done_c ? '0 : seen_nx_c;
            frame_valid <= done_c;
            err         <= accept_c && !dec_valid_c;
            if (done_c) begin
                value <= nib_nx_c;
                dp_o  <= dp_nx_c;
            end
        end
    end

`ifdef SEG7_CAP_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (accept_c && !dec_valid_c && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_module_seg7_capture.sv
// Self-checking bench for module_seg7_capture: directed scans plus randomized dwells vs a dwell-level model.
module tb_module_seg7_capture;

    localparam int unsigned STABLE = 4;
    localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  an  = 4'hF;
    logic [15:0] value;
    logic [3:0]  dp_o;
    logic        frame_valid;
    logic        err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    module_seg7_capture #(.STABLE_CNT(STABLE), .N_DIG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .dp_o        (dp_o),
        .frame_valid (frame_valid),
        .err         (err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    // Observed frames and err pulses
    logic [19:0] got_q[$];
    int          got_err = 0;

    always @(negedge clk) begin
        if (frame_valid) got_q.push_back({value, dp_o});
        if (err) got_err++;
    end

    // Dwell-level reference model
    logic [19:0] exp_q[$];
    logic [3:0]  last_an  = 4'hF;
    logic [7:0]  last_seg = 8'hFF;
    int          run      = 0;
    bit          acc_done = 0;
    logic [3:0]  m_seen   = 4'h0;
    logic [15:0] m_nib    = 16'h0;
    logic [3:0]  m_dp     = 4'h0;
    int          m_err_pulses = 0;
    int          m_err_total  = 0;

    function automatic int exp_errcnt();
`ifdef SEG7_CAP_ERRCNT_EN
        return (m_err_total > 255) ? 255 : m_err_total;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        last_an = 4'hF; last_seg = 8'hFF; run = 0; acc_done = 0;
        m_seen = 4'h0; m_nib = 16'h0; m_dp = 4'h0;
        m_err_pulses = 0; m_err_total = 0;
    endfunction

    function automatic void model_dwell(input logic [3:0] a, input logic [7:0] s, input int len);
        int d;
        int hit;
        bit legal;
        legal = ($countones(~a) == 1);
        if (a == last_an && s == last_seg) run += len;
        else begin
            run = len;
            acc_done = 0;
        end
        last_an = a;
        last_seg = s;
        if (legal && run >= int'(STABLE) && !acc_done) begin
            acc_done = 1;
            d = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) d = i;
            hit = -1;
            for (int k = 0; k < 16; k++) if (PAT[k] == s[6:0]) hit = k;
            if (hit < 0) begin
                m_err_pulses++;
                m_err_total++;
            end else begin
                m_nib[d*4 +: 4] = 4'(hit);
                m_dp[d] = ~s[7];
                m_seen[d] = 1'b1;
                if (m_seen == 4'hF) begin
                    exp_q.push_back({m_nib, m_dp});
                    m_seen = 4'h0;
                end
            end
        end
    endfunction

    task automatic drive_dwell(input logic [3:0] a, input logic [7:0] s, input int len);
        model_dwell(a, s, len);
        an = a;
        seg = s;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] s3, input logic [3:0] mask, input int len);
        logic [7:0] sv [4];
        logic [3:0] a;
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                a = ~(4'b0001 << i);
                drive_dwell(a, sv[i], len);
            end
        end
    endtask

    task automatic idle(input int len);
        drive_dwell(4'hF, 8'hFF, len);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        got_err = 0;
        m_err_pulses = 0;
    endtask

    task automatic do_reset();
        an = 4'hF;
        seg = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        clear_obs();
    endtask

    task automatic test_reset();
        do_reset();
        idle(2);
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h want=0000", value); end
        total++; if (dp_o !== 4'h0) begin bad++; $display("FAIL reset_dp got=%b want=0000", dp_o); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_errcnt got=%h want=00", err_cnt); end
    endtask

    task automatic test_scan_basic();
        clear_obs();
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'hF, 8);
        idle(5);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL basic_frames got=%0d want=1", got_q.size()); end
        total++;
        if (got_q.size() < 1 || got_q[0] !== {16'h3210, 4'b0000}) begin
            bad++; $display("FAIL basic_value got=%h want=%h", (got_q.size() > 0) ? got_q[0] : 20'h0, {16'h3210, 4'b0000});
        end
    endtask

    task automatic test_dp();
        clear_obs();
        scan(8'h8E, 8'h86, 8'h21, 8'hC6, 4'hF, 8);
        idle(5);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL dp_frames got=%0d want=1", got_q.size()); end
        total++; if (value !== 16'hCDEF) begin bad++; $display("FAIL dp_value got=%h want=cdef", value); end
        total++; if (dp_o !== 4'b0100) begin bad++; $display("FAIL dp_bits got=%b want=0100", dp_o); end
    endtask

    task automatic test_short_dwell();
        clear_obs();
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1101, 8);
        drive_dwell(4'b1101, 8'hF9, 3);
        idle(6);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL short_no_frame got=%0d want=0", got_q.size()); end
        drive_dwell(4'b1101, 8'hF9, 4);
        idle(5);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL short_frame got=%0d want=1", got_q.size()); end
        total++; if (value !== 16'h3210) begin bad++; $display("FAIL short_value got=%h want=3210", value); end
    endtask

    task automatic test_err();
        clear_obs();
        model_dwell(4'b1110, 8'hFF, 8);
        an = 4'b1110;
        seg = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (err !== (k == int'(STABLE) + 2)) begin
                bad++; $display("FAIL err_timing edge=%0d got=%b want=%b", k, err, (k == int'(STABLE) + 2));
            end
        end
        idle(4);
        total++; if (got_err !== 1) begin bad++; $display("FAIL err_pulses got=%0d want=1", got_err); end
        total++;
        if (int'(err_cnt) !== exp_errcnt()) begin
            bad++; $display("FAIL err_cnt got=%0d want=%0d", err_cnt, exp_errcnt());
        end
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1110, 8);
        idle(5);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL err_seen_kept got=%0d want=0", got_q.size()); end
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0001, 8);
        idle(5);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL err_then_frame got=%0d want=1", got_q.size()); end
    endtask

    task automatic test_two_low();
        clear_obs();
        drive_dwell(4'b1100, 8'hC0, 10);
        total++; if (got_q.size() !== 0 || got_err !== 0) begin
            bad++; $display("FAIL two_low_quiet frames=%0d errs=%0d want=0/0", got_q.size(), got_err);
        end
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'hF, 8);
        idle(5);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL two_low_frames got=%0d want=1", got_q.size()); end
        total++; if (value !== 16'h3210) begin bad++; $display("FAIL two_low_value got=%h want=3210", value); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0111, 8);
        do_reset();
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1000, 8);
        idle(5);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rstmid_frames got=%0d want=0", got_q.size()); end
        total++; if (value !== 16'h0000 || dp_o !== 4'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%h/%b want=0000/0000", value, dp_o);
        end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rstmid_errcnt got=%h want=00", err_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] s;
        int         len;
        int         n;
        for (int round = 0; round < 4; round++) begin
            clear_obs();
            for (int j = 0; j < 60; j++) begin
                if ($urandom_range(9) < 8) a = ~(4'b0001 << $urandom_range(3));
                else a = 4'($urandom_range(15));
                if ($urandom_range(9) < 8) s = {1'($urandom_range(1)), PAT[$urandom_range(15)]};
                else s = 8'($urandom_range(255));
                len = $urandom_range(10, 1);
                drive_dwell(a, s, len);
            end
            idle(6);
            total++;
            if (got_q.size() !== exp_q.size()) begin
                bad++; $display("FAIL rand%0d_frames got=%0d want=%0d", round, got_q.size(), exp_q.size());
            end
            n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
            for (int i = 0; i < n; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand%0d_frame%0d got=%h want=%h", round, i, got_q[i], exp_q[i]);
                end
            end
            total++;
            if (got_err !== m_err_pulses) begin
                bad++; $display("FAIL rand%0d_errs got=%0d want=%0d", round, got_err, m_err_pulses);
            end
            total++;
            if (int'(err_cnt) !== exp_errcnt()) begin
                bad++; $display("FAIL rand%0d_errcnt got=%0d want=%0d", round, err_cnt, exp_errcnt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_dp();
        test_short_dwell();
        test_err();
        test_two_low();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
